memory_nrw_wb: RTL and testbench

//  N-port pipelined Wishbone (B4) on-chip RAM; successor to the 2-port SRAM wrapper.

---
 rtl/memory_wb_pkg.sv | 15 +
 rtl/memory_wb_resp_pipe.sv | 40 ++++
 rtl/memory_nrw_wb.sv | 115 +++++++++++
 tb/tb_memory_nrw_wb.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_wb_pkg.sv
// Shared types and constants for the multi-port Wishbone RAM and its response pipes.
package memory_wb_pkg;

    localparam int BYTE_W      = 8;
    localparam int WB_ADR_W    = 32;
    localparam int MAX_PORTS   = 4;
    localparam int RESP_DATA_W = 32;

    typedef struct packed {
        logic                   valid;
        logic                   err;
        logic [RESP_DATA_W-1:0] data;
    } resp_t;

endpackage

// File: rtl/memory_wb_resp_pipe.sv
// Per-port response shift register of DEPTH stages; flush drops everything in flight.
// Payload data is held across bubbles so dat_o keeps its last value while ack is low.
module memory_wb_resp_pipe
    import memory_wb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic  wb_clk_i,
    input  logic  wb_rst_ni,
    input  logic  flush,
    input  resp_t resp_in,
    output resp_t resp_out
);

    resp_t [DEPTH:0] stage;

    assign stage[0] = resp_in;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
            resp_t stage_reg;

            always_ff @(posedge wb_clk_i) begin
                if (!wb_rst_ni) begin
                    stage_reg <= '0;
                end else if (stage[gi].valid && !flush) begin
                    stage_reg <= stage[gi];
                end else begin
                    stage_reg.valid <= 1'b0;
                    stage_reg.err   <= 1'b0;
                end
            end

            assign stage[gi+1] = stage_reg;
        end
    endgenerate

    assign resp_out = stage[DEPTH];

endmodule

// File: rtl/memory_nrw_wb.sv
// N-port pipelined Wishbone B4 RAM with fixed-priority same-word collision stalls.
// Define MEMORY_BOUNDS_CHECK_EN to answer requests outside BASE_ADDR with err_o.
module memory_nrw_wb
    import memory_wb_pkg::*;
#(
    parameter int          NUM_PORTS    = 2,
    parameter int          DATA_WIDTH   = 32,
    parameter int          ADDR_WIDTH   = 9,
    parameter int          READ_LATENCY = 1,
    parameter logic [31:0] BASE_ADDR    = 32'h0
) (
    input  logic                                wb_clk_i,
    input  logic                                wb_rst_ni,
    input  logic [NUM_PORTS-1:0]                wb_cyc_i,
    input  logic [NUM_PORTS-1:0]                wb_stb_i,
    input  logic [NUM_PORTS-1:0]                wb_we_i,
    input  logic [NUM_PORTS*WB_ADR_W-1:0]       wb_adr_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [NUM_PORTS*DATA_WIDTH/8-1:0]   wb_sel_i,
    output logic [NUM_PORTS-1:0]                wb_stall_o,
    output logic [NUM_PORTS-1:0]                wb_ack_o,
    output logic [NUM_PORTS-1:0]                wb_err_o,
    output logic [NUM_PORTS*DATA_WIDTH-1:0]     wb_dat_o
);

    localparam int NUM_WMASKS = DATA_WIDTH / BYTE_W;
    localparam int DEPTH      = 1 << ADDR_WIDTH;
    localparam int HI_W       = WB_ADR_W - ADDR_WIDTH - 2;

    generate
        if (NUM_PORTS < 1 || NUM_PORTS > MAX_PORTS || DATA_WIDTH > RESP_DATA_W ||
            (DATA_WIDTH % BYTE_W) != 0 || READ_LATENCY < 1 || READ_LATENCY > 2) begin : g_bad_cfg
            $error("memory_nrw_wb: unsupported parameter set");
        end
    endgenerate

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0] word;
    logic [NUM_PORTS-1:0]                 req;
    logic [NUM_PORTS-1:0]                 in_range;
    logic [NUM_PORTS-1:0]                 accept;

    // Address bits below the word and (without bounds checking) above it are don't-care.
    logic unused_sigs;
    assign unused_sigs = ^{wb_adr_i, BASE_ADDR};

    // A higher port yields whenever a lower port hits the same word and either side writes.
    always_comb begin
        wb_stall_o = '0;
        for (int q = 1; q < NUM_PORTS; q++) begin
            for (int p = 0; p < q; p++) begin
                if (req[p] && req[q] && in_range[p] && in_range[q] &&
                    word[p] == word[q] && (wb_we_i[p] || wb_we_i[q])) begin
                    wb_stall_o[q] = 1'b1;
                end
            end
        end
    end

    assign accept = req & ~wb_stall_o & {NUM_PORTS{wb_rst_ni}};

    always_ff @(posedge wb_clk_i) begin
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (accept[p] && wb_we_i[p] && in_range[p]) begin
                for (int b = 0; b < NUM_WMASKS; b++) begin
                    if (wb_sel_i[p*NUM_WMASKS + b]) begin
                        mem[word[p]][b*BYTE_W +: BYTE_W] <= wb_dat_i[(p*NUM_WMASKS + b)*BYTE_W +: BYTE_W];
                    end
                end
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            resp_t resp_in;
            resp_t resp_out;

            assign word[gi] = wb_adr_i[gi*WB_ADR_W + 2 +: ADDR_WIDTH];
            assign req[gi]  = wb_cyc_i[gi] & wb_stb_i[gi];
`ifdef MEMORY_BOUNDS_CHECK_EN
            assign in_range[gi] = (wb_adr_i[gi*WB_ADR_W + ADDR_WIDTH + 2 +: HI_W] ==
                                   BASE_ADDR[WB_ADR_W-1:ADDR_WIDTH+2]);
`else
            assign in_range[gi] = 1'b1;
`endif

            // Sampled together with the write edge, so reads see the pre-write word.
            always_comb begin
                resp_in       = '0;
                resp_in.valid = accept[gi];
                resp_in.err   = accept[gi] & ~in_range[gi];
                if (in_range[gi]) begin
                    resp_in.data = RESP_DATA_W'(mem[word[gi]]);
                end
            end

            memory_wb_resp_pipe #(
                .DEPTH(READ_LATENCY)
            ) u_resp_pipe (
                .wb_clk_i (wb_clk_i),
                .wb_rst_ni(wb_rst_ni),
                .flush    (~wb_cyc_i[gi]),
                .resp_in  (resp_in),
                .resp_out (resp_out)
            );

            assign wb_ack_o[gi] = resp_out.valid & ~resp_out.err;
            assign wb_err_o[gi] = resp_out.valid &  resp_out.err;
            assign wb_dat_o[gi*DATA_WIDTH +: DATA_WIDTH] = resp_out.data[DATA_WIDTH-1:0];
        end
    endgenerate

endmodule

// File: tb/tb_memory_nrw_wb.sv
// Scoreboard bench for memory_nrw_wb: 2 ports, 32-bit data, 9-bit word address, latency 2.
module tb_memory_nrw_wb;

    localparam int NP = 2;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int RL = 2;
    localparam int NB = DW / 8;
`ifdef MEMORY_BOUNDS_CHECK_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    logic               wb_clk_i = 1'b0;
    logic               wb_rst_ni = 1'b0;
    logic [NP-1:0]      wb_cyc_i = '0;
    logic [NP-1:0]      wb_stb_i = '0;
    logic [NP-1:0]      wb_we_i = '0;
    logic [NP*32-1:0]   wb_adr_i = '0;
    logic [NP*DW-1:0]   wb_dat_i = '0;
    logic [NP*NB-1:0]   wb_sel_i = '0;
    logic [NP-1:0]      wb_stall_o;
    logic [NP-1:0]      wb_ack_o;
    logic [NP-1:0]      wb_err_o;
    logic [NP*DW-1:0]   wb_dat_o;

    always #5 wb_clk_i = ~wb_clk_i;

    memory_nrw_wb #(
        .NUM_PORTS   (NP),
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .READ_LATENCY(RL),
        .BASE_ADDR   (32'h0)
    ) dut (
        .wb_clk_i  (wb_clk_i),
        .wb_rst_ni (wb_rst_ni),
        .wb_cyc_i  (wb_cyc_i),
        .wb_stb_i  (wb_stb_i),
        .wb_we_i   (wb_we_i),
        .wb_adr_i  (wb_adr_i),
        .wb_dat_i  (wb_dat_i),
        .wb_sel_i  (wb_sel_i),
        .wb_stall_o(wb_stall_o),
        .wb_ack_o  (wb_ack_o),
        .wb_err_o  (wb_err_o),
        .wb_dat_o  (wb_dat_o)
    );

    typedef struct {
        int            due;
        logic          ack;
        logic          err;
        logic          chk;
        logic [DW-1:0] data;
    } ent_t;

    ent_t          exp_q [NP][$];
    ent_t          obs_q [NP][$];
    logic [DW-1:0] model [1<<AW];
    logic [NP-1:0] last_stall;
    int            cycle = 0;
    int            pass_cnt = 0;
    int            check_cnt = 0;

    function automatic logic out_of_range(logic [31:0] a);
        return BOUNDS_EN && (a[31:AW+2] != '0);
    endfunction

    task automatic drive(int p, logic we, logic [31:0] adr, logic [DW-1:0] dat, logic [NB-1:0] sel);
        wb_cyc_i[p] = 1'b1;
        wb_stb_i[p] = 1'b1;
        wb_we_i[p]  = we;
        wb_adr_i[p*32 +: 32] = adr;
        wb_dat_i[p*DW +: DW] = dat;
        wb_sel_i[p*NB +: NB] = sel;
    endtask

    task automatic hold(int p);
        wb_cyc_i[p] = 1'b1;
        wb_stb_i[p] = 1'b0;
        wb_we_i[p]  = 1'b0;
    endtask

    // One bus cycle: collect responses, predict accepts into the scoreboard, cross the edge.
    task automatic step();
        logic [NP-1:0] acc;
        logic [AW-1:0] w;
        logic          oob;
        @(negedge wb_clk_i);
        for (int p = 0; p < NP; p++) begin
            if (wb_ack_o[p] || wb_err_o[p])
                obs_q[p].push_back('{due: cycle, ack: wb_ack_o[p], err: wb_err_o[p], chk: 1'b1,
                                     data: wb_dat_o[p*DW +: DW]});
            if (!wb_cyc_i[p])
                while (exp_q[p].size() > 0 && exp_q[p][exp_q[p].size()-1].due > cycle)
                    void'(exp_q[p].pop_back());
        end
        last_stall = wb_stall_o;
        for (int p = 0; p < NP; p++) begin
            acc[p] = wb_rst_ni && wb_cyc_i[p] && wb_stb_i[p] && !wb_stall_o[p];
            if (acc[p]) begin
                w   = wb_adr_i[p*32 + 2 +: AW];
                oob = out_of_range(wb_adr_i[p*32 +: 32]);
                exp_q[p].push_back('{due: cycle + RL, ack: !oob, err: oob, chk: (!wb_we_i[p] || oob),
                                     data: oob ? '0 : model[w]});
                $display("[cyc %0d] p%0d %s adr=%h dat=%h sel=%h", cycle, p, wb_we_i[p] ? "WR" : "RD",
                         wb_adr_i[p*32 +: 32], wb_dat_i[p*DW +: DW], wb_sel_i[p*NB +: NB]);
            end
        end
        for (int p = 0; p < NP; p++) begin
            w = wb_adr_i[p*32 + 2 +: AW];
            if (acc[p] && wb_we_i[p] && !out_of_range(wb_adr_i[p*32 +: 32]))
                for (int b = 0; b < NB; b++)
                    if (wb_sel_i[p*NB + b]) model[w][b*8 +: 8] = wb_dat_i[p*DW + b*8 +: 8];
        end
        @(posedge wb_clk_i);
        #1;
        cycle++;
    endtask

    task automatic finish_test();
        for (int p = 0; p < NP; p++) hold(p);
        repeat (RL + 2) step();
        wb_cyc_i = '0;
        step();
    endtask

    task automatic test_reset();
        wb_rst_ni = 1'b0;
        drive(0, 1'b0, 32'h40, '0, 4'hF);
        drive(1, 1'b0, 32'h44, '0, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge wb_clk_i);
            check_cnt++;
            if (wb_ack_o !== '0) $display("FAIL reset_ack: got %b expected 0", wb_ack_o); else pass_cnt++;
            check_cnt++;
            if (wb_err_o !== '0) $display("FAIL reset_err: got %b expected 0", wb_err_o); else pass_cnt++;
            check_cnt++;
            if (wb_dat_o !== '0) $display("FAIL reset_dat: got %h expected 0", wb_dat_o); else pass_cnt++;
        end
        @(posedge wb_clk_i);
        #1;
        wb_rst_ni = 1'b1;
        hold(0);
        hold(1);
        repeat (RL + 3) step();
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != 0) $display("FAIL reset_spurious p%0d: got %0d responses expected 0", p, obs_q[p].size());
            else pass_cnt++;
            obs_q[p].delete();
            exp_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_write_read();
        ent_t e, o;
        logic [DW-1:0] got;
        drive(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF); hold(1); step();
        hold(0); drive(1, 1'b0, 32'h10, '0, 4'hF); step();
        hold(1);
        for (int p = 0; p < NP; p++) hold(p);
        repeat (RL + 2) step();
        got = (obs_q[1].size() > 0) ? obs_q[1][0].data : 'x;
        check_cnt++;
        if (got !== 32'hDEADBEEF) $display("FAIL wr_rd_data: got %h expected deadbeef", got); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != exp_q[p].size())
                $display("FAIL wr_rd_count p%0d: got %0d expected %0d", p, obs_q[p].size(), exp_q[p].size());
            else pass_cnt++;
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL wr_rd_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_byte_mask();
        ent_t e, o;
        logic [DW-1:0] got;
        hold(1);
        drive(0, 1'b1, 32'h10, 32'h11223344, 4'b0101); step();
        drive(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000); step();
        drive(0, 1'b0, 32'h10, '0, 4'hF); step();
        hold(0);
        repeat (RL + 2) step();
        got = (obs_q[0].size() > 2) ? obs_q[0][2].data : 'x;
        check_cnt++;
        if (got !== 32'hDE22BE44) $display("FAIL mask_data: got %h expected de22be44", got); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != exp_q[p].size())
                $display("FAIL mask_count p%0d: got %0d expected %0d", p, obs_q[p].size(), exp_q[p].size());
            else pass_cnt++;
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL mask_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_collision();
        ent_t e, o;
        logic [DW-1:0] got;
        drive(0, 1'b1, 32'h20, 32'hA5A5A5A5, 4'hF);
        drive(1, 1'b1, 32'h20, 32'h5A5A5A5A, 4'hF);
        step();
        check_cnt++;
        if (last_stall !== 2'b10) $display("FAIL coll_ww_stall: got %b expected 10", last_stall); else pass_cnt++;
        hold(0);
        step();
        check_cnt++;
        if (last_stall !== 2'b00) $display("FAIL coll_retry_stall: got %b expected 00", last_stall); else pass_cnt++;
        hold(1);
        drive(0, 1'b0, 32'h20, '0, 4'hF); step();
        drive(0, 1'b0, 32'h20, '0, 4'hF);
        drive(1, 1'b0, 32'h20, '0, 4'hF);
        step();
        check_cnt++;
        if (last_stall !== 2'b00) $display("FAIL coll_rr_stall: got %b expected 00", last_stall); else pass_cnt++;
        hold(0); hold(1);
        repeat (RL + 2) step();
        got = (obs_q[0].size() > 1) ? obs_q[0][1].data : 'x;
        check_cnt++;
        if (got !== 32'h5A5A5A5A) $display("FAIL coll_final: got %h expected 5a5a5a5a", got); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != exp_q[p].size())
                $display("FAIL coll_count p%0d: got %0d expected %0d", p, obs_q[p].size(), exp_q[p].size());
            else pass_cnt++;
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL coll_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_back_to_back();
        ent_t e, o;
        int   span;
        hold(1);
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 32'h100 + 32'(i*4), 32'h10000000 + 32'(i) * 32'h01111111, 4'hF);
            step();
        end
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b0, 32'h100 + 32'(i*4), '0, 4'hF);
            step();
        end
        hold(0);
        repeat (RL + 2) step();
        span = (obs_q[0].size() == 8) ? (obs_q[0][7].due - obs_q[0][4].due) : -1;
        check_cnt++;
        if (span != 3) $display("FAIL b2b_span: got %0d expected 3", span); else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != exp_q[p].size())
                $display("FAIL b2b_count p%0d: got %0d expected %0d", p, obs_q[p].size(), exp_q[p].size());
            else pass_cnt++;
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL b2b_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_abort();
        ent_t e, o;
        hold(1);
        drive(0, 1'b0, 32'h100, '0, 4'hF); step();
        drive(0, 1'b0, 32'h104, '0, 4'hF); step();
        wb_cyc_i[0] = 1'b0;
        wb_stb_i[0] = 1'b0;
        repeat (RL + 4) step();
        check_cnt++;
        if (obs_q[0].size() != 1) $display("FAIL abort_count: got %0d responses expected 1", obs_q[0].size());
        else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL abort_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    task automatic test_bounds();
        ent_t e, o;
        logic [DW-1:0] got;
        logic          got_err;
        hold(1);
        drive(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF); step();
        drive(0, 1'b1, 32'h800, 32'h12345678, 4'hF); step();
        drive(0, 1'b0, 32'h0, '0, 4'hF); step();
        hold(0);
        repeat (RL + 2) step();
        got_err = (obs_q[0].size() > 1) ? obs_q[0][1].err : 1'bx;
        check_cnt++;
        if (got_err !== BOUNDS_EN) $display("FAIL bounds_err: got %b expected %b", got_err, BOUNDS_EN); else pass_cnt++;
        got = (obs_q[0].size() > 2) ? obs_q[0][2].data : 'x;
        check_cnt++;
        if (got !== (BOUNDS_EN ? 32'hCAFEF00D : 32'h12345678))
            $display("FAIL bounds_word0: got %h expected %h", got, BOUNDS_EN ? 32'hCAFEF00D : 32'h12345678);
        else pass_cnt++;
        for (int p = 0; p < NP; p++) begin
            check_cnt++;
            if (obs_q[p].size() != exp_q[p].size())
                $display("FAIL bounds_count p%0d: got %0d expected %0d", p, obs_q[p].size(), exp_q[p].size());
            else pass_cnt++;
            while (exp_q[p].size() > 0 && obs_q[p].size() > 0) begin
                e = exp_q[p].pop_front(); o = obs_q[p].pop_front();
                check_cnt++;
                if (o.due != e.due || o.ack !== e.ack || o.err !== e.err || (e.chk && o.data !== e.data))
                    $display("FAIL bounds_resp p%0d: got cyc %0d ack %b err %b dat %h expected cyc %0d ack %b err %b dat %h",
                             p, o.due, o.ack, o.err, o.data, e.due, e.ack, e.err, e.data);
                else pass_cnt++;
            end
            exp_q[p].delete(); obs_q[p].delete();
        end
        finish_test();
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask();
        test_collision();
        test_back_to_back();
        test_abort();
        test_bounds();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
